fetch_stage: RTL and testbench

- Instruction-fetch front end that feeds the decode/execute datapath of the RISC-V core.
- Holds the program counter, reads the asynchronous instruction ROM, and buffers fetched {pc, instr} pairs in a 2-entry skid FIFO.
- Presents those pairs to the consumer through a valid/ready handshake.
- Accepts branch/jump redirects and a halt request from the downstream stage.

---
 rtl/fetch_stage.sv | 216 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end with 2-entry skid FIFO
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined     : a redirect whose target[1:0] != 0 flushes the FIFO, keeps pc, halts
//                 fetch and sets the sticky misaligned flag
//   not defined : redirect targets are forced word aligned; misaligned is tied to 0
//
// fetch_skid_fifo ports:
//   clk_i, resetn_i          clock, synchronous active-low reset
//   flush_i                  discard all entries (wins over push/pop)
//   s_tvalid_i/s_tdata_i     write side; s_tready_o = room or simultaneous pop
//   m_tvalid_o/m_tready_i    read side handshake; m_tdata_o is 0 when empty
//   count_o                  occupancy 0..2
//
// fetch_stage ports:
//   clk, reset               core clock, synchronous active-low reset
//   initial_address          pc loaded while reset is low
//   imem_addr/imem_rdata     asynchronous ROM address (= pc) and read data
//   redirect_valid/_target   taken branch/jump, new pc
//   halt_req                 stop fetching
//   out_valid/out_ready      head entry handshake
//   out_pc/out_instr         head entry contents (0 when empty)
//   out_pc_plus4             out_pc + 4, wrapping
//   halted, misaligned       HALT state, sticky misaligned-redirect flag
//   buf_count                FIFO occupancy

module fetch_skid_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         resetn_i,
   input  logic         flush_i,
   input  logic         s_tvalid_i,
   input  logic [W-1:0] s_tdata_i,
   output logic         s_tready_o,
   output logic         m_tvalid_o,
   input  logic         m_tready_i,
   output logic [W-1:0] m_tdata_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         push, pop;

   assign m_tvalid_o = (count_q != 2'd0);
   assign m_tdata_o  = m_tvalid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o    = count_q;

   // Popping frees the head slot, so a full FIFO still accepts a write that cycle.
   assign pop        = m_tvalid_o & m_tready_i;
   assign s_tready_o = (count_q < 2'(DEPTH)) | pop;
   assign push       = s_tvalid_i & s_tready_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Data storage needs no reset: an empty FIFO masks its outputs to zero.
   always_ff @(posedge clk_i) begin
      if (resetn_i && push && !flush_i) begin
         mem_q[wr_ptr_q] <= s_tdata_i;
      end
   end

endmodule

module fetch_stage #(
   parameter int XLEN      = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] initial_address,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            halt_req,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc_plus4,
   output logic            halted,
   output logic            misaligned,
   output logic [1:0]      buf_count
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              fetch_en;
   logic              fifo_ready;
   logic [2*XLEN-1:0] head_data;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic              misaligned_q, misaligned_d;
`endif

   fetch_skid_fifo #(
      .W     (2 * XLEN),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk_i      (clk),
      .resetn_i   (reset),
      .flush_i    (redirect_valid),
      .s_tvalid_i (fetch_en),
      .s_tdata_i  ({pc_q, imem_rdata}),
      .s_tready_o (fifo_ready),
      .m_tvalid_o (out_valid),
      .m_tready_i (out_ready),
      .m_tdata_o  (head_data),
      .count_o    (buf_count)
   );

   assign imem_addr    = pc_q;
   assign out_pc       = head_data[2*XLEN-1:XLEN];
   assign out_instr    = head_data[XLEN-1:0];
   assign out_pc_plus4 = out_pc + XLEN'(4);
   assign halted       = (state_q == ST_HALT);

   // Priority: redirect > halt_req > fetch. Neither a redirect nor the halt
   // transition edge pushes; a redirect also discards any pop (flush).
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      fetch_en = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_d = misaligned_q;
`endif
      if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
         if (redirect_target[1:0] != 2'b00) begin
            state_d      = ST_HALT;
            misaligned_d = 1'b1;
         end else begin
            pc_d    = redirect_target;
            state_d = ST_RUN;
         end
`else
         pc_d    = redirect_target & ~XLEN'(3);
         state_d = ST_RUN;
`endif
      end else if (state_q == ST_RUN) begin
         if (halt_req) begin
            state_d = ST_HALT;
         end else begin
            fetch_en = 1'b1;
            // pc only advances when the fetched word is actually stored.
            if (fifo_ready) begin
               pc_d = pc_q + XLEN'(4);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_RUN;
         pc_q    <= initial_address;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         misaligned_q <= 1'b0;
      end else begin
         misaligned_q <= misaligned_d;
      end
   end

   assign misaligned = misaligned_q;
`else
   assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage

module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] initial_address;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        halt_req;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_pc_plus4;
   logic        halted;
   logic        misaligned;
   logic [1:0]  buf_count;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [31:0] exp_q[$];
   logic        done = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   assign imem_rdata = rom_word(imem_addr);

   fetch_stage #(.XLEN(32), .BUF_DEPTH(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .initial_address (initial_address),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .halt_req        (halt_req),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_instr       (out_instr),
      .out_pc_plus4    (out_pc_plus4),
      .halted          (halted),
      .misaligned      (misaligned),
      .buf_count       (buf_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut(input logic [31:0] addr);
      reset           = 1'b0;
      initial_address = addr;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic check_reset_state(input string tag, input logic [31:0] addr);
      check({tag, "_out_valid"},    {31'd0, out_valid},  32'd0);
      check({tag, "_out_pc"},       out_pc,              32'd0);
      check({tag, "_out_instr"},    out_instr,           32'd0);
      check({tag, "_out_pc_plus4"}, out_pc_plus4,        32'd4);
      check({tag, "_halted"},       {31'd0, halted},     32'd0);
      check({tag, "_buf_count"},    {30'd0, buf_count},  32'd0);
      check({tag, "_misaligned"},   {31'd0, misaligned}, 32'd0);
      check({tag, "_imem_addr"},    imem_addr,           addr);
   endtask

   initial begin
      reset           = 1'b0;
      initial_address = 32'h0000_0100;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      halt_req        = 1'b0;
      out_ready       = 1'b0;

      fork
         // Monitor: every accepted head entry must match the oldest expectation.
         begin
            while (!done) begin
               @(negedge clk);
               if (!done && out_valid === 1'b1 && out_ready === 1'b1) begin
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_fails++;
                     $display("FAIL unexpected_pop: got pc 0x%08h expected no transfer", out_pc);
                  end else begin
                     logic [31:0] e;
                     e = exp_q.pop_front();
                     check("sb_out_pc",       out_pc,       e);
                     check("sb_out_instr",    out_instr,    rom_word(e));
                     check("sb_out_pc_plus4", out_pc_plus4, e + 32'd4);
                  end
               end
            end
         end

         // Stimulus
         begin
            // Reset flow
            reset_dut(32'h0000_0100);
            check_reset_state("rst1", 32'h0000_0100);
            tick();
            check("first_valid", {31'd0, out_valid}, 32'd1);
            check("first_pc",    out_pc,             32'h0000_0100);
            exp_q.push_back(32'h0000_0100);
            exp_q.push_back(32'h0000_0104);
            exp_q.push_back(32'h0000_0108);
            out_ready = 1'b1;
            repeat (3) tick();
            out_ready = 1'b0;
            check("flow_count", {30'd0, buf_count}, 32'd1);
            check("flow_head",  out_pc,             32'h0000_010C);

            // Backpressure from a fresh reset
            reset_dut(32'h0000_0100);
            repeat (5) tick();
            check("bp_count", {30'd0, buf_count}, 32'd2);
            check("bp_pc",    out_pc,             32'h0000_0100);
            check("bp_imem",  imem_addr,          32'h0000_0108);
            exp_q.push_back(32'h0000_0100);
            exp_q.push_back(32'h0000_0104);
            exp_q.push_back(32'h0000_0108);
            out_ready = 1'b1;
            repeat (3) tick();
            out_ready = 1'b0;
            check("bp_after_count", {30'd0, buf_count}, 32'd2);
            check("bp_after_head",  out_pc,             32'h0000_010C);

            // Redirect with full FIFO
            redirect_valid  = 1'b1;
            redirect_target = 32'h0000_0040;
            tick();
            redirect_valid = 1'b0;
            check("rd_count", {30'd0, buf_count}, 32'd0);
            check("rd_valid", {31'd0, out_valid}, 32'd0);
            check("rd_imem",  imem_addr,          32'h0000_0040);
            tick();
            check("rd_pc",    out_pc,             32'h0000_0040);
            exp_q.push_back(32'h0000_0040);
            exp_q.push_back(32'h0000_0044);
            out_ready = 1'b1;
            repeat (2) tick();
            out_ready = 1'b0;

            // Halt at pc=0x20 with one entry buffered
            redirect_valid  = 1'b1;
            redirect_target = 32'h0000_001C;
            tick();
            redirect_valid = 1'b0;
            tick();
            check("pre_halt_count", {30'd0, buf_count}, 32'd1);
            check("pre_halt_imem",  imem_addr,          32'h0000_0020);
            halt_req = 1'b1;
            tick();
            halt_req = 1'b0;
            check("halt_halted", {31'd0, halted},    32'd1);
            check("halt_count",  {30'd0, buf_count}, 32'd1);
            exp_q.push_back(32'h0000_001C);
            out_ready = 1'b1;
            repeat (3) tick();
            out_ready = 1'b0;
            check("drain_valid",  {31'd0, out_valid}, 32'd0);
            check("drain_imem",   imem_addr,          32'h0000_0020);
            check("drain_halted", {31'd0, halted},    32'd1);
            redirect_valid  = 1'b1;
            redirect_target = 32'h0000_0000;
            tick();
            redirect_valid = 1'b0;
            check("unhalt_halted", {31'd0, halted},    32'd0);
            check("unhalt_bubble", {31'd0, out_valid}, 32'd0);
            tick();
            check("unhalt_valid", {31'd0, out_valid}, 32'd1);
            exp_q.push_back(32'h0000_0000);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;

            // Wrap-around
            reset_dut(32'hFFFF_FFF8);
            tick();
            exp_q.push_back(32'hFFFF_FFF8);
            exp_q.push_back(32'hFFFF_FFFC);
            exp_q.push_back(32'h0000_0000);
            out_ready = 1'b1;
            repeat (3) tick();
            out_ready = 1'b0;
            tick();
            check("wrap_full", {30'd0, buf_count}, 32'd2);

            // Reset beats a simultaneous redirect on a full FIFO
            reset           = 1'b0;
            initial_address = 32'h0000_0300;
            redirect_valid  = 1'b1;
            redirect_target = 32'h0000_0500;
            tick();
            check_reset_state("rst2", 32'h0000_0300);
            redirect_valid = 1'b0;
            tick();
            reset = 1'b1;
            tick();

            // Misaligned redirect
            redirect_valid  = 1'b1;
            redirect_target = 32'h0000_0042;
            tick();
            redirect_valid = 1'b0;
            check("mis_count", {30'd0, buf_count}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
            check("mis_flag",   {31'd0, misaligned}, 32'd1);
            check("mis_halted", {31'd0, halted},     32'd1);
            check("mis_imem",   imem_addr,           32'h0000_0304);
            redirect_valid  = 1'b1;
            redirect_target = 32'h0000_0080;
            tick();
            redirect_valid = 1'b0;
            check("mis_exit_halted", {31'd0, halted},     32'd0);
            check("mis_sticky",      {31'd0, misaligned}, 32'd1);
            check("mis_exit_imem",   imem_addr,           32'h0000_0080);
`else
            check("mis_flag",   {31'd0, misaligned}, 32'd0);
            check("mis_halted", {31'd0, halted},     32'd0);
            check("mis_imem",   imem_addr,           32'h0000_0040);
            tick();
            check("mis_valid", {31'd0, out_valid}, 32'd1);
            check("mis_pc",    out_pc,             32'h0000_0040);
            check("mis_instr", out_instr,          rom_word(32'h0000_0040));
`endif

            check("scoreboard_drained", exp_q.size(), 32'd0);
            done = 1'b1;
         end
      join

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
